uart_transmitter: RTL
=====================

// Module: uart_transmitter
// PURPOSE
//  Serialises one parallel word per request into an asynchronous UART frame on Tx_out.
//  Frame: 1 start (0), data_width data bits LSB first, optional parity, 1 stop (1).
//  Pairs with the UART receiver and is driven by the same 8x-baud tick source (baud_clkx8).
//  Sits between the host logic and the serial pin.
// PARAMETERS
//  data_width  8  number of data bits per frame (8, 16, 32 ...)
// PORTS
//  clock          in   1           system clock; all logic on posedge
//  resetn         in   1           asynchronous, active-low reset
//  baud_clkx8     in   1           square wave at 8x baud, asynchronous to clock
//  tx_start       in   1           request; sampled only in ST_IDLE
//  data_in        in   data_width  word to send; captured on the accepted request
//  Tx_out         out  1           serial line; idles high
//  tx_busy        out  1           high from the cycle after acceptance until return to ST_IDLE
//  one_data_sent  out  1           high for 8 clock cycles after the stop bit completes
// BEHAVIOUR
//  Reset (async, resetn=0): Tx_out=1, tx_busy=0, one_data_sent=0, state=ST_IDLE.
//   All counters and the shift register clear. A reset mid-frame forces Tx_out high immediately.
//  Tick: baud_clkx8 passes through 2 flops (d, d1); tick = d & ~d1, one clock wide.
//   Bit period = exactly 8 ticks.
//  States and transitions:
//   ST_IDLE  : Tx_out=1. If tx_start: shreg<=data_in, tx_busy<=1 -> ST_SYNC.
//   ST_SYNC  : wait for first tick; on tick Tx_out<=0, tick_cnt<=0 -> ST_START.
//   ST_START : count ticks; on 8th tick Tx_out<=shreg[0], shift right, bit_cnt<=1 -> ST_DATA.
//   ST_DATA  : on 8th tick:
//              if bit_cnt<data_width, output next bit, bit_cnt++;
//              else -> ST_PARITY (macro on) or ST_STOP (Tx_out<=1).
//   ST_PARITY: Tx_out = parity bit for 8 ticks, then Tx_out<=1 -> ST_STOP.
//   ST_STOP  : Tx_out=1; on 8th tick one_data_sent<=1, hold_cnt<=0 -> ST_DONE.
//   ST_DONE  : one_data_sent high for 8 clocks (hold_cnt 0..7);
//              then one_data_sent<=0, tx_busy<=0 -> ST_IDLE.
//  Handshake:
//   - tx_start outside ST_IDLE is ignored; it is not queued.
//   - data_in changes after acceptance have no effect.
//   - A tx_start held high re-triggers on the first ST_IDLE cycle, giving back-to-back frames
//     separated by 1 idle clock plus ST_SYNC.
//  Counters:
//   - tick_cnt is 3 bits; it wraps 7->0 on the 8th tick of each bit.
//   - bit_cnt is sized $clog2(data_width+1).
//  Latency: accept -> start edge = 1 clock + wait for first tick (<= one baud_clkx8 period).
//   Frame = (10 + parity) x 8 ticks.
//  Simultaneous tick and state entry: a tick is consumed only by the state it arrives in.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//   - ST_PARITY is inserted after the data bits.
//   - Parity bit = ^data_in (captured) when PARITY_ODD=0 (even parity), ~^ otherwise.
//   - PARITY_ODD is a localparam, default 0.
//  UART_TX_PARITY_EN undefined: ST_PARITY and the parity logic are absent;
//   ST_DATA goes straight to ST_STOP.
// STRUCTURE
//  Shared header uart_defs.vh holds:
//   - state encodings ST_* (3 bits)
//   - TICKS_PER_BIT=8
//   - HOLD_CYCLES=8
//   - PARITY_ODD
//  The receiver uses the same header.
//  Sub-module uart_tick_edge: 2-flop synchroniser plus rising-edge detector producing tick.
//   Reusable by the receiver.
// TESTING
//  (baud_clkx8 period = 16 clocks, so bit = 128 clocks; data_width=8)
//  1 Basic frame: data_in=8'hA5, pulse tx_start.
//    -> Tx_out = 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each bit 8 ticks;
//       one_data_sent high 8 clocks; tx_busy falls together with it.
//  2 Loopback: Tx_out into the UART receiver; send 8'h00, 8'hFF, 8'h3C.
//    -> receiver data_bus matches each word, its flag fires once per frame.
//  3 Busy ignore: tx_start pulsed mid-frame with data_in=8'h11.
//    -> current frame unchanged; no second frame starts.
//  4 Back-to-back: tx_start held high, data_in 8'h55 then 8'hAA.
//    -> two complete frames, Tx_out high >= 1 clock between the stop bit and the next start.
//  5 Async reset mid-frame (during data bit 3): resetn low.
//    -> Tx_out=1, tx_busy=0, one_data_sent=0 without a clock edge.
//       After release, a new 8'hC3 frame is correct.
//  6 Parity (UART_TX_PARITY_EN): 8'hA5 -> parity bit 0; 8'hA4 -> parity bit 1; 11-bit frame.
//    Build without the macro -> 10-bit frame.

Source files
------------

// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: state encoding, bit/hold timing and parity sense.
// UART_TX_PARITY_EN: when defined, the parity stage and its configuration are available.
package uart_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5,
        ST_DONE   = 3'd6
    } tx_state_t;

    localparam int unsigned TICKS_PER_BIT = 8;
    localparam int unsigned HOLD_CYCLES   = 8;

`ifdef UART_TX_PARITY_EN
    // 0 = even parity, 1 = odd parity
    localparam bit PARITY_ODD = 1'b0;
`endif

endpackage

// File: rtl/uart_tick_edge.sv
// Brings the 8x-baud square wave into the clock domain and emits a
// one-clock tick on each of its rising edges.
module uart_tick_edge (
    input  logic clock,
    input  logic resetn,
    input  logic baud_clkx8,
    output logic tick
);

    logic d;
    logic d1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            d  <= 1'b0;
            d1 <= 1'b0;
        end else begin
            d  <= baud_clkx8;
            d1 <= d;
        end
    end

    assign tick = d & ~d1;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, data_width data bits LSB first, optional parity, stop bit.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int unsigned data_width = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  baud_clkx8,
    input  logic                  tx_start,
    input  logic [data_width-1:0] data_in,
    output logic                  Tx_out,
    output logic                  tx_busy,
    output logic                  one_data_sent
);

    localparam int unsigned     BCW       = $clog2(data_width + 1);
    localparam logic [BCW-1:0]  LAST_BIT  = BCW'(data_width);
    localparam logic [2:0]      TICK_LAST = 3'(TICKS_PER_BIT - 1);
    localparam logic [2:0]      HOLD_LAST = 3'(HOLD_CYCLES - 1);

    tx_state_t             state, state_d;
    logic                  tx_d, busy_d, sent_d;
    logic [data_width-1:0] shreg, shreg_d;
    logic [2:0]            tick_cnt, tick_cnt_d;
    logic [BCW-1:0]        bit_cnt, bit_cnt_d;
    logic [2:0]            hold_cnt, hold_cnt_d;
    logic                  tick;
    logic                  last_tick;
`ifdef UART_TX_PARITY_EN
    logic                  parity, parity_d;
`endif

    uart_tick_edge u_tick_edge (
        .clock      (clock),
        .resetn     (resetn),
        .baud_clkx8 (baud_clkx8),
        .tick       (tick)
    );

    assign last_tick = tick && (tick_cnt == TICK_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            Tx_out        <= 1'b1;
            tx_busy       <= 1'b0;
            one_data_sent <= 1'b0;
            shreg         <= '0;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            hold_cnt      <= '0;
`ifdef UART_TX_PARITY_EN
            parity        <= 1'b0;
`endif
        end else begin
            state         <= state_d;
            Tx_out        <= tx_d;
            tx_busy       <= busy_d;
            one_data_sent <= sent_d;
            shreg         <= shreg_d;
            tick_cnt      <= tick_cnt_d;
            bit_cnt       <= bit_cnt_d;
            hold_cnt      <= hold_cnt_d;
`ifdef UART_TX_PARITY_EN
            parity        <= parity_d;
`endif
        end
    end

    // The tick that moves SYNC to START is not counted; each bit then spans 8 further ticks.
    always_comb begin
        state_d    = state;
        tx_d       = Tx_out;
        busy_d     = tx_busy;
        sent_d     = one_data_sent;
        shreg_d    = shreg;
        tick_cnt_d = tick_cnt;
        bit_cnt_d  = bit_cnt;
        hold_cnt_d = hold_cnt;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity;
`endif
        if (tick && state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
            tick_cnt_d = tick_cnt + 3'd1;
        end

        case (state)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    shreg_d  = data_in;
                    busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^data_in) ^ PARITY_ODD;
`endif
                    state_d  = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (tick) begin
                    tx_d       = 1'b0;
                    tick_cnt_d = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (last_tick) begin
                    tx_d      = shreg[0];
                    shreg_d   = shreg >> 1;
                    bit_cnt_d = BCW'(1);
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_tick) begin
                    if (bit_cnt < LAST_BIT) begin
                        tx_d      = shreg[0];
                        shreg_d   = shreg >> 1;
                        bit_cnt_d = bit_cnt + BCW'(1);
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity;
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (last_tick) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (last_tick) begin
                    sent_d     = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (hold_cnt == HOLD_LAST) begin
                    sent_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt + 3'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
